// File: rtl/lfsr_pair_pkg.sv
// Shared types and constants for the LFSR operand-pair generator.
// Holds the FSM state enum, LFSR geometry, feedback taps and the default seed.
package lfsr_pair_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LFSR_W = 16;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

    // Condition flagged alongside each pair when the condition output is built.
    function automatic logic cond_match(input logic [7:0] a, input logic [7:0] b);
        return ((a[3] == b[3]) && (a[2] != b[2])) || (a == 8'h00);
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational single step of the 16-bit Fibonacci LFSR (taps 15,13,12,10).
module lfsr16_step
    import lfsr_pair_pkg::*;
(
    input  logic [LFSR_W-1:0] s,
    output logic [LFSR_W-1:0] next
);

    logic fb;

    assign fb      = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    assign next[0] = fb;

    generate
        for (genvar gi = 0; gi < LFSR_W - 1; gi++) begin : g_shift
            assign next[gi+1] = s[gi];
        end
    endgenerate

endmodule

// File: rtl/lfsr_pair_gen.sv
// Bounded stream of pseudo-random operand pairs over valid/ready.
// Optional condition flag and counter are built when LFSR_PAIR_GEN_COND_EN is defined.
module lfsr_pair_gen #(
    parameter int          WIDTH        = 8,
    parameter int          NUM_VEC      = 9,
    parameter logic [15:0] SEED_DEFAULT = lfsr_pair_pkg::SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_count
`ifdef LFSR_PAIR_GEN_COND_EN
    ,
    output logic             cond_out,
    output logic [15:0]      cond_count
`endif
);

    import lfsr_pair_pkg::*;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

    state_t            state_reg, state_next;
    logic [LFSR_W-1:0] lfsr_reg, lfsr_next, lfsr_step;
    logic [15:0]       vec_count_reg, vec_count_next;
    logic              out_valid_reg, out_valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              xfer;

    lfsr16_step u_step (
        .s    (lfsr_reg),
        .next (lfsr_step)
    );

    assign xfer = out_valid_reg && out_ready;

    always_comb begin
        state_next     = state_reg;
        lfsr_next      = lfsr_reg;
        vec_count_next = vec_count_reg;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Seed is applied before start so a same-cycle start runs from it.
                if (seed_load)
                    lfsr_next = (seed == 16'h0000) ? SEED_DEFAULT : seed;
                if (start) begin
                    state_next     = RUN;
                    vec_count_next = 16'h0000;
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            RUN: begin
                out_valid_next = 1'b1;
                busy_next      = 1'b1;
                if (xfer) begin
                    lfsr_next      = lfsr_step;
                    vec_count_next = vec_count_reg + 16'd1;
                    if (vec_count_reg == LAST_IDX) begin
                        state_next     = DONE;
                        out_valid_next = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            lfsr_reg      <= SEED_DEFAULT;
            vec_count_reg <= 16'h0000;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lfsr_reg      <= lfsr_next;
            vec_count_reg <= vec_count_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign a_out     = lfsr_reg[LFSR_W-1 -: WIDTH];
    assign b_out     = lfsr_reg[WIDTH-1:0];
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign vec_count = vec_count_reg;

`ifdef LFSR_PAIR_GEN_COND_EN
    logic [15:0] cond_count_reg, cond_count_next;
    logic        cond_now;

    assign cond_now = cond_match(lfsr_reg[15:8], lfsr_reg[7:0]);

    always_comb begin
        cond_count_next = cond_count_reg;
        if (state_reg == IDLE && start)
            cond_count_next = 16'h0000;
        else if (xfer && cond_now)
            cond_count_next = cond_count_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cond_count_reg <= 16'h0000;
        else
            cond_count_reg <= cond_count_next;
    end

    assign cond_out   = out_valid_reg && cond_now;
    assign cond_count = cond_count_reg;
`else
    // Plain pair stream only: no condition tracking in this build.
`endif

endmodule

// File: doc/lfsr_pair_gen.md
Name: lfsr_pair_gen

Overview:
Stimulus source for the 8-bit logical-operator stage. Produces a bounded stream of pseudo-random operand pairs (a, b) from a 16-bit Fibonacci LFSR and presents them over a valid/ready interface. The downstream operator/monitor block consumes the stream. The pattern is deterministic and seed-reproducible, so result logs can be diffed between runs.

Parameters:
WIDTH, 8, width of each operand a_out / b_out; fixed at 8 in this revision.
NUM_VEC, 9, number of pairs emitted per start; legal range 1..65535.
SEED_DEFAULT, 16'hACE1, LFSR value after reset; also substituted for a zero seed.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
seed_load  in  1  load seed into LFSR; honoured only in IDLE
seed  in  16  seed value for seed_load
a_out  out  8  operand a = lfsr[15:8]
b_out  out  8  operand b = lfsr[7:0]
out_valid  out  1  a_out/b_out hold a valid pair
out_ready  in  1  consumer accepts the pair when high with out_valid
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last pair is accepted
vec_count  out  16  pairs accepted in the current or most recent run

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, lfsr=SEED_DEFAULT, out_valid=0, busy=0, done=0, vec_count=0. rst overrides every other input, including mid-run; any pair in flight is dropped.
- LFSR step: fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}. The LFSR advances only on a transfer (out_valid && out_ready).
- seed_load in IDLE: lfsr <= (seed==0) ? SEED_DEFAULT : seed. A zero seed is never loaded, so the LFSR cannot lock up.
- seed_load and start in the same IDLE cycle: the seed is loaded first, and the run begins from the new seed.
- seed_load and start are ignored outside IDLE.
- States:
  - IDLE: out_valid=0. On start: go to RUN, clear vec_count to 0, set busy=1.
  - RUN: out_valid=1 from the first cycle after start, so start-to-first-valid latency is 1 cycle.
    - a_out/b_out reflect the current lfsr and must stay stable while out_valid && !out_ready.
    - On each transfer: lfsr steps and vec_count increments.
    - On the transfer where vec_count becomes NUM_VEC: go to DONE. out_valid falls on the next cycle, so no bubble or extra pair follows.
  - DONE: one cycle with done=1, busy=0, out_valid=0, then go to IDLE.
- vec_count holds its value in IDLE until the next start.
- The LFSR state persists across runs. A second start without seed_load continues the sequence.
- out_ready low for any number of cycles: output holds and the LFSR does not advance.
- out_ready high continuously: one pair per cycle, so the run spans NUM_VEC cycles of out_valid.
- All outputs are registered; there is no combinational path from out_ready to out_valid.

Optional Feature:
Macro: LFSR_PAIR_GEN_COND_EN
- Defined: adds output cond_out (1 bit), qualified by out_valid and aligned with a_out/b_out.
  - cond_out = ((a_out[3]==b_out[3]) && (a_out[2]!=b_out[2])) || (a_out==0).
  - Also adds cond_count (16 bits): the number of accepted pairs with cond_out=1 in the current run. It clears on start and resets to 0.
- Undefined: neither port exists, and no logic is added.

Decomposition:
- Shared package lfsr_pair_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR_W=16;
  - tap constants 15, 13, 12, 10;
  - SEED_DEFAULT.
- One sub-module, lfsr16_step, is natural: a combinational next-state function with input s[15:0] and output next[15:0]. The step logic is thereby reusable by the bench's reference model.
- The FSM, counter and handshake stay in lfsr_pair_gen.

Test Plan:
- Reset, then start with out_ready=1 and NUM_VEC=9 -> first pair a=8'hAC, b=8'hE1. Second pair a=8'h59, b=8'hC3. Exactly 9 valid cycles, done pulses once, vec_count=9.
- seed_load with seed=16'h0000, then start -> first pair a=8'hAC, b=8'hE1 (zero seed replaced by SEED_DEFAULT).
- seed_load with seed=16'h1234 in the same cycle as start -> first pair a=8'h12, b=8'h34.
- During RUN, hold out_ready=0 for 5 cycles after the first valid -> a_out/b_out stay 8'hAC/8'hE1 and vec_count stays 0. The sequence resumes identically once out_ready=1.
- Assert rst on the cycle of the 4th transfer -> next cycle out_valid=0, busy=0, vec_count=0, lfsr=16'hACE1. A new start replays the pair 8'hAC/8'hE1.
- With LFSR_PAIR_GEN_COND_EN, seed 16'h0004 -> pair a=8'h00, b=8'h04 gives cond_out=1, and cond_count increments on acceptance.
